des_perm_pipe: RTL and testbench

- Parametrised, pipelined bit-permutation engine for the DES datapath.
- Applies the initial permutation (IP) or the final permutation (FP = IP^-1) to a 64-bit block, selected per transaction.
- Optional half-swap before FP absorbs the DES R16/L16 swap.
- Valid/ready elastic pipeline with tag passthrough; sits between the block I/O buffers and the round engine (IP) and between the round engine and output (FP).

---
 rtl/des_perm_pipe.sv | 128 ++++++++++++
 tb/tb_des_perm_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_perm_pipe.sv
// Pipelined DES IP/FP bit-permutation engine with a valid/ready elastic
// pipeline; the permutation is done ahead of stage 1 and later stages only carry.
module des_perm_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:64]      in_data,
  input  logic             in_mode,
  input  logic             in_swap,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:64]      out_data,
  output logic [1:32]      out_L,
  output logic [1:32]      out_R,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("des_perm_pipe: STAGES must be in 1..4");
    end
  endgenerate

  localparam int IPT [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FPT [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
  };

  logic [1:64] x_w;
  logic [1:64] perm_w;

  // The half swap only matters on the FP path; IP ignores in_swap.
  assign x_w = (in_mode && in_swap) ? {in_data[33:64], in_data[1:32]} : in_data;

  genvar gi;
  generate
    for (gi = 1; gi <= 64; gi++) begin : g_perm
      assign perm_w[gi] = in_mode ? x_w[FPT[gi]] : in_data[IPT[gi]];
    end
  endgenerate

  // Index 0 is the pipeline input; index i is the output of stage i.
  logic [STAGES:0]  v_w;
  logic [STAGES:0]  mode_w;
  logic [1:64]      data_w [0:STAGES];
  logic [TAG_W-1:0] tag_w  [0:STAGES];

  assign v_w[0]    = in_valid;
  assign mode_w[0] = in_mode;
  assign data_w[0] = perm_w;
  assign tag_w[0]  = in_tag;

  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      logic             valid_q, valid_d;
      logic             mode_q, mode_d;
      logic [1:64]      data_q, data_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic             ld_w;

      // A stage can load unless it and every stage after it are full and the sink stalls.
      assign ld_w = out_ready | ~(&v_w[STAGES:gi]);

      always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (ld_w) begin
          valid_d = v_w[gi-1];
          if (v_w[gi-1]) begin
            mode_d = mode_w[gi-1];
            data_d = data_w[gi-1];
            tag_d  = tag_w[gi-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          mode_q  <= 1'b0;
          data_q  <= '0;
          tag_q   <= '0;
        end else begin
          valid_q <= valid_d;
          mode_q  <= mode_d;
          data_q  <= data_d;
          tag_q   <= tag_d;
        end
      end

      assign v_w[gi]    = valid_q;
      assign mode_w[gi] = mode_q;
      assign data_w[gi] = data_q;
      assign tag_w[gi]  = tag_q;
    end
  endgenerate

  assign in_ready  = out_ready | ~(&v_w[STAGES:1]);
  assign out_valid = v_w[STAGES];
  assign out_data  = data_w[STAGES];
  assign out_L     = data_w[STAGES][1:32];
  assign out_R     = data_w[STAGES][33:64];
  assign out_mode  = mode_w[STAGES];
  assign out_tag   = tag_w[STAGES];
  assign busy      = |v_w[STAGES:1];

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: a queue-based behavioural model (table-driven
// permutation plus in-order occupancy/latency rules) checked every cycle.
module tb_des_perm_pipe;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [1:64]      in_data = '0;
  logic             in_mode = 1'b0;
  logic             in_swap = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:64]      out_data;
  logic [1:32]      out_L;
  logic [1:32]      out_R;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;

  des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_mode(in_mode), .in_swap(in_swap), .in_tag(in_tag),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_L(out_L), .out_R(out_R), .out_mode(out_mode),
    .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int IPT [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
  int FPT [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // DES bit b (1 = MSB) lives at vector index 64-b.
  function automatic logic [63:0] perm(input logic [63:0] x, input bit fp);
    logic [63:0] r;
    for (int k = 1; k <= 64; k++)
      r[64-k] = x[64 - (fp ? FPT[k-1] : IPT[k-1])];
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] d, input logic m, input logic s);
    if (!m) return perm(d, 0);
    return perm(s ? {d[31:0], d[63:32]} : d, 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0]      data;
    logic             mode;
    logic [TAG_W-1:0] tag;
    int               acc;
  } ent_t;

  ent_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are sampled mid-cycle; the transfers seen here happen at the next rising edge.
  always @(negedge clk) begin
    ent_t e;
    bit   exp_v;
    if (rst_n) begin
      exp_v = (q.size() > 0) && (cyc - q[0].acc >= STAGES - 1);
      chk("out_valid", out_valid, exp_v);
      chk("busy", busy, q.size() > 0);
      chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
      if (out_valid && q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_L", out_L, q[0].data[63:32]);
        chk("out_R", out_R, q[0].data[31:0]);
        chk("out_mode", out_mode, q[0].mode);
        chk("out_tag", out_tag, q[0].tag);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          $display("OUT tag=%0d mode=%0d data=%h", out_tag, out_mode, out_data);
          if (q.size() > 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          e.data = model(in_data, in_mode, in_swap);
          e.mode = in_mode;
          e.tag  = in_tag;
          e.acc  = cyc + 1;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single block through an empty pipeline with out_ready high; checks latency and value.
  task automatic dir(input logic [63:0] d, input logic m, input logic s,
                     input logic [TAG_W-1:0] t, input logic [63:0] exp, input string name);
    int k;
    out_ready = 1'b1;
    in_data = d; in_mode = m; in_swap = s; in_tag = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk({name, "_latency"}, k, STAGES);
    chk(name, out_data, exp);
    chk({name, "_L"}, out_L, exp[63:32]);
    chk({name, "_R"}, out_R, exp[31:0]);
    chk({name, "_tag"}, out_tag, t);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] bp_d [5];
    logic [63:0] x;
    int idx, outs, sent, c;
    bit acc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    chk("pin_ip", model(64'h0123456789ABCDEF, 0, 0), 64'hCC00CCFFF0AAF0AA);
    chk("pin_fp_swap", model(64'hF0AAF0AACC00CCFF, 1, 1), 64'h0123456789ABCDEF);
    chk("pin_ip_bit58", model(64'h0000000000000040, 0, 0), 64'h8000000000000000);
    chk("pin_fp_bit", model(64'h8000000000000000, 1, 0), 64'h0000000000000040);

    dir(64'h0123456789ABCDEF, 0, 0, 3, 64'hCC00CCFFF0AAF0AA, "ip_vec");
    dir(64'h0123456789ABCDEF, 0, 1, 9, 64'hCC00CCFFF0AAF0AA, "ip_swap_ignored");
    dir(64'hF0AAF0AACC00CCFF, 1, 1, 5, 64'h0123456789ABCDEF, "fp_swap");
    dir(64'hF0AAF0AACC00CCFF, 1, 0, 6, model(64'hF0AAF0AACC00CCFF, 1, 0), "fp_noswap");
    dir(64'h0000000000000040, 0, 0, 7, 64'h8000000000000000, "ip_bit58");
    dir(64'h8000000000000000, 1, 0, 8, 64'h0000000000000040, "fp_bit");

    // Backpressure: only STAGES blocks fit while the sink stalls.
    for (int i = 0; i < 5; i++) bp_d[i] = {$urandom, $urandom};
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (idx < 5);
      in_data = bp_d[idx % 5]; in_mode = 1'b0; in_swap = 1'b0; in_tag = TAG_W'(idx + 1);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, STAGES);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 5);
      in_data = bp_d[idx % 5]; in_tag = TAG_W'(idx + 1);
      if (out_valid) outs++;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_rate", outs, 5);
    chk("bp_all_accepted", idx, 5);
    repeat (STAGES + 2) tick();

    // Flush with two blocks in flight; the same-cycle input is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = {$urandom, $urandom}; in_tag = TAG_W'(10 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b1; in_data = {$urandom, $urandom}; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    dir(64'h0123456789ABCDEF, 0, 0, 4, 64'hCC00CCFFF0AAF0AA, "after_flush");

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = {$urandom, $urandom}; in_tag = TAG_W'(12 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_in_ready", in_ready, 1);
    dir(64'hF0AAF0AACC00CCFF, 1, 1, 2, 64'h0123456789ABCDEF, "after_reset");

    // Random stream with random stalls on both sides.
    sent = 0;
    c = 0;
    in_valid = 1'b0;
    while (sent < 1000 && c < 20000) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        x = {$urandom, $urandom};
        in_data = x; in_mode = $urandom_range(1); in_swap = $urandom_range(1);
        in_tag = TAG_W'(sent); in_valid = 1'b1;
        if (sent % 100 == 0) chk("round_trip", model(model(x, 0, 0), 1, 0), x);
      end
      out_ready = ($urandom_range(2) != 0);
      acc = in_valid && in_ready;
      tick();
      c++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("rand_sent", sent, 1000);
    out_ready = 1'b1;
    c = 0;
    while (q.size() > 0 && c < 50) begin
      tick();
      c++;
    end
    tick();
    chk("rand_drained", q.size(), 0);
    chk("rand_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
